fifo_write_arbiter: RTL



---
 rtl/fifo_write_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin, burst-limited arbiter sharing the write port of an async FIFO
// among NumReq valid/ready requesters. Lives entirely in the write-clock domain.
//
// Handshake: requester i's word is accepted in a cycle where
// ReqValid[i] & ReqReady[i] are both high; ReqReady never depends on
// ReqValid of the same requester, and at most one ReqReady bit is high.
//
// FSM state is visible externally through Busy (IDLE=0, BURST=1).
// GrantId doubles as the "last owner" pointer: it holds the previous owner
// while idle, which is exactly where the round-robin search restarts.
//
// Optional feature macro: FIFO_WRITE_ARBITER_STALL_CNT_EN adds the 16-bit
// saturating FullStallCount output (cycles a granted, valid requester was
// blocked by full).
module fifo_write_arbiter #(
  parameter int NumReq   = 4,
  parameter int DataSize = 3,
  parameter int MaxBurst = 4,
  parameter int IdWidth  = $clog2(NumReq)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NumReq-1:0]            ReqValid,
  input  logic [NumReq*DataSize-1:0]   ReqData,
  output logic [NumReq-1:0]            ReqReady,
  input  logic                         full,
  output logic                         Push,
  output logic [DataSize-1:0]          DataIn,
  output logic [NumReq-1:0]            Grant,
  output logic [IdWidth-1:0]           GrantId,
  output logic                         Busy
`ifdef FIFO_WRITE_ARBITER_STALL_CNT_EN
  ,
  output logic [15:0]                  FullStallCount
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IdWidth-1:0]   grant_id_q, grant_id_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;

  logic [IdWidth-1:0]   pick;
  logic                 sel_valid;
  logic [DataSize-1:0]  sel_data;
  logic                 in_burst;
  logic                 transfer;
  logic [NumReq-1:0]    owner_onehot;

  // Round-robin search: first valid requester after the last owner, with wrap.
  // The last owner is visited last, so it has the lowest priority.
  always_comb begin
    int  idx;
    logic found;
    pick  = grant_id_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(grant_id_q) + i) % NumReq;
      if (!found && ReqValid[idx]) begin
        found = 1'b1;
        pick  = IdWidth'(idx);
      end
    end
  end

  // Datapath selection and write-port strobes; reset suppresses any push.
  always_comb begin
    in_burst     = (state_q == BURST);
    sel_valid    = ReqValid[grant_id_q];
    sel_data     = ReqData[grant_id_q*DataSize +: DataSize];
    owner_onehot = {{(NumReq-1){1'b0}}, 1'b1} << grant_id_q;
    transfer     = in_burst & sel_valid & ~full & ~reset;

    Push     = transfer;
    ReqReady = (in_burst & ~full & ~reset) ? owner_onehot : '0;
    DataIn   = (in_burst & ~reset) ? sel_data : '0;
    Grant    = in_burst ? owner_onehot : '0;
    GrantId  = grant_id_q;
    Busy     = in_burst;
  end

  // Next-state: grant in IDLE, count transfers in BURST, leave on the final
  // transfer or when the owner withdraws.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (|ReqValid) begin
          state_d     = BURST;
          grant_id_d  = pick;
          burst_cnt_d = 8'd0;
        end
      end
      BURST: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (transfer) begin
          if (burst_cnt_q == 8'(MaxBurst - 1)) begin
            state_d = IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset parks the last-owner pointer at NumReq-1 so req0
  // wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_id_q  <= IdWidth'(NumReq - 1);
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_WRITE_ARBITER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the owner had data but the FIFO was full.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (in_burst && sel_valid && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign FullStallCount = stall_cnt_q;
`endif

endmodule
